// File: rtl/rtc_transaction_sequencer.sv
// Request sequencer for the RTC bus-control timing generator: drives the write/read
// enables, the outgoing bus byte and read capture. Optional watchdog: RTC_SEQ_TIMEOUT_EN.
module rtc_transaction_sequencer #(
  parameter int unsigned GAP_CYCLES = 3,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       en_esc,
  output logic       en_lect,
  input  logic       dir1,
  input  logic       dat1,
  input  logic       cambio_est,
  input  logic [7:0] bus_din,
  output logic [7:0] bus_dout,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // The generator's counter needs at least two low cycles to rearm.
  if (GAP_CYCLES < 2 || TIMEOUT < 2) begin : g_param_check
    $error("rtc_transaction_sequencer: GAP_CYCLES and TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             op_write, op_write_nx;
  logic [7:0]       op_addr, op_addr_nx;
  logic [7:0]       op_wdata, op_wdata_nx;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;
  logic [7:0]       cap, cap_nx;
  logic             en_esc_nx, en_lect_nx, rsp_valid_nx, rsp_err_nx;
  logic [7:0]       bus_dout_nx, rsp_rdata_nx;
  logic             timeout_hit;

`ifdef RTC_SEQ_TIMEOUT_EN
  logic [7:0] wdog;

  // Watchdog sits at zero outside XFER, so it starts from zero on every entry.
  always_ff @(posedge clk) begin
    if (reset || state != XFER) wdog <= 8'd0;
    else                        wdog <= wdog + 8'd1;
  end

  assign timeout_hit = (wdog == 8'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_write  <= 1'b0;
      op_addr   <= 8'd0;
      op_wdata  <= 8'd0;
      gap_cnt   <= '0;
      cap       <= 8'd0;
      en_esc    <= 1'b0;
      en_lect   <= 1'b0;
      bus_dout  <= 8'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
      rsp_err   <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      op_write  <= op_write_nx;
      op_addr   <= op_addr_nx;
      op_wdata  <= op_wdata_nx;
      gap_cnt   <= gap_cnt_nx;
      cap       <= cap_nx;
      en_esc    <= en_esc_nx;
      en_lect   <= en_lect_nx;
      bus_dout  <= bus_dout_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_err   <= rsp_err_nx;
      req_ready <= (state_nx == IDLE);
      busy      <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx     = state;
    op_write_nx  = op_write;
    op_addr_nx   = op_addr;
    op_wdata_nx  = op_wdata;
    gap_cnt_nx   = gap_cnt;
    cap_nx       = cap;
    en_esc_nx    = 1'b0;
    en_lect_nx   = 1'b0;
    bus_dout_nx  = bus_dout;
    rsp_valid_nx = 1'b0;
    rsp_rdata_nx = rsp_rdata;
    rsp_err_nx   = rsp_err;

    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nx    = XFER;
          op_write_nx = req_write;
          op_addr_nx  = req_addr;
          op_wdata_nx = req_wdata;
          cap_nx      = 8'd0;
          en_esc_nx   = req_write;
          en_lect_nx  = !req_write;
        end
      end

      XFER: begin
        en_esc_nx  = op_write;
        en_lect_nx = !op_write;
        if (dir1)                 bus_dout_nx = op_addr;
        else if (dat1 && op_write) bus_dout_nx = op_wdata;
        if (dat1 && !op_write) cap_nx = bus_din;

        // A completion in the same cycle as the timeout takes priority.
        if (cambio_est) begin
          state_nx     = GAP;
          gap_cnt_nx   = '0;
          en_esc_nx    = 1'b0;
          en_lect_nx   = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b0;
          rsp_rdata_nx = op_write ? 8'd0 : (dat1 ? bus_din : cap);
        end else if (timeout_hit) begin
          state_nx     = GAP;
          gap_cnt_nx   = '0;
          en_esc_nx    = 1'b0;
          en_lect_nx   = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b1;
          rsp_rdata_nx = 8'd0;
        end
      end

      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nx = IDLE;
        else                                   gap_cnt_nx = gap_cnt + GAP_W'(1);
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rtc_transaction_sequencer.sv
// Directed self-checking bench for rtc_transaction_sequencer (GAP_CYCLES=3, TIMEOUT=16).
// The timeout scenario runs when RTC_SEQ_TIMEOUT_EN is defined.
module tb_rtc_transaction_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       en_esc, en_lect;
  logic       dir1, dat1, cambio_est;
  logic [7:0] bus_din, bus_dout;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rtc_transaction_sequencer #(.GAP_CYCLES(3), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .en_esc(en_esc), .en_lect(en_lect),
    .dir1(dir1), .dat1(dat1), .cambio_est(cambio_est),
    .bus_din(bus_din), .bus_dout(bus_dout),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("wait_idle", req_ready, 1);
  endtask

  initial begin
    int n, low_in_gap;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    dir1 = 1'b0; dat1 = 1'b0; cambio_est = 1'b0; bus_din = 8'h00;
    tick(); tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_en", {en_esc, en_lect}, 0);
    chk("rst_dout", bus_dout, 8'h00);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    reset = 1'b0;
    tick();

    // Write 0x15 to 0x21
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h21; req_wdata = 8'h15;
    tick();
    req_valid = 1'b0;
    chk("wr_en_esc", en_esc, 1);
    chk("wr_en_lect", en_lect, 0);
    chk("wr_busy_ready", {busy, req_ready}, 2'b10);
    dir1 = 1'b1;
    tick();
    chk("wr_dout_addr", bus_dout, 8'h21);
    dir1 = 1'b0; dat1 = 1'b1;
    tick();
    chk("wr_dout_data", bus_dout, 8'h15);
    chk("wr_en_hold", {en_esc, en_lect}, 2'b10);
    dat1 = 1'b0; cambio_est = 1'b1;
    tick();
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_rdata", rsp_rdata, 8'h00);
    chk("wr_en_drop", {en_esc, en_lect}, 0);
    tick();
    cambio_est = 1'b0;
    chk("wr_rsp_single", rsp_valid, 0);
    chk("wr_gap_busy", busy, 1);
    tick();
    chk("wr_gap_not_ready", req_ready, 0);
    tick();
    chk("wr_ready_after_gap", req_ready, 1);

    // Read from 0x22, bus returns 0x47
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h22; req_wdata = 8'hEE;
    tick();
    req_valid = 1'b0;
    chk("rd_en", {en_esc, en_lect}, 2'b01);
    dir1 = 1'b1;
    tick();
    chk("rd_dout_addr", bus_dout, 8'h22);
    dir1 = 1'b0; dat1 = 1'b1; bus_din = 8'h47;
    tick();
    chk("rd_dout_hold1", bus_dout, 8'h22);
    tick();
    chk("rd_dout_hold2", bus_dout, 8'h22);
    dat1 = 1'b0; bus_din = 8'h99; cambio_est = 1'b1;
    tick();
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 8'h47);
    chk("rd_rsp_err", rsp_err, 0);
    tick();
    cambio_est = 1'b0;
    chk("rd_rdata_stable", {rsp_valid, rsp_rdata}, {1'b0, 8'h47});
    wait_idle();

    // Back-to-back: write then read, req_valid held high
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h30; req_wdata = 8'h5A;
    tick();
    req_write = 1'b0; req_addr = 8'h31;
    chk("b2b_wr_en", en_esc, 1);
    tick(); tick();
    cambio_est = 1'b1;
    tick();
    cambio_est = 1'b0;
    chk("b2b_rsp1", rsp_valid, 1);
    n = 0; low_in_gap = 0;
    while (!en_lect && n < 20) begin
      if (busy && !en_esc && !en_lect) low_in_gap++;
      tick();
      n++;
    end
    // Enables stay low through the GAP cycles plus the single IDLE accept cycle.
    chk("b2b_accept_dist", n, 4);
    chk("b2b_low_in_gap", low_in_gap, 3);
    chk("b2b_rd_en", {en_esc, en_lect}, 2'b01);
    req_valid = 1'b0;
    cambio_est = 1'b1;
    tick();
    cambio_est = 1'b0;
    chk("b2b_rsp2", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 8'h00});
    wait_idle();

    // Spurious generator flags in IDLE
    cambio_est = 1'b1; dir1 = 1'b1; dat1 = 1'b1; bus_din = 8'h77;
    tick();
    cambio_est = 1'b0; dir1 = 1'b0; dat1 = 1'b0;
    chk("spur_rsp", rsp_valid, 0);
    chk("spur_state", {req_ready, busy}, 2'b10);
    chk("spur_dout", bus_dout, 8'h22);
    tick();
    chk("spur_rsp_later", {rsp_valid, req_ready, en_esc, en_lect}, 4'b0100);

    // Reset in the middle of a write
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40; req_wdata = 8'h01;
    tick();
    req_valid = 1'b0;
    chk("rst_mid_en_before", en_esc, 1);
    dir1 = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; dir1 = 1'b0;
    chk("rst_mid_en", {en_esc, en_lect}, 0);
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_rsp", rsp_valid, 0);
    chk("rst_mid_dout", bus_dout, 8'h00);
    cambio_est = 1'b1;
    tick();
    cambio_est = 1'b0;
    chk("rst_mid_no_rsp", {rsp_valid, busy}, 0);

`ifdef RTC_SEQ_TIMEOUT_EN
    // Read with no completion: watchdog aborts on the 16th XFER cycle
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h50;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("to_pending", {rsp_valid, busy, en_lect}, 3'b011);
    tick();
    chk("to_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b11, 8'h00});
    chk("to_en_drop", en_lect, 0);
    tick();
    chk("to_gap", {rsp_valid, rsp_err, busy}, 3'b011);
    wait_idle();
`else
    // Without the watchdog a transfer waits indefinitely
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h50;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("nowd_waiting", {rsp_valid, rsp_err, busy, en_lect}, 4'b0011);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("nowd_recover", {req_ready, en_lect}, 2'b10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
